// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and constants for the register-file sequencer
package regfile_seq_pkg;

  localparam int OP_WIDTH        = 6;
  localparam int MAX_ALU_LATENCY = 16;
  localparam int CNT_WIDTH       = $clog2(MAX_ALU_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

  // 74181 op codes packed as {M, Cn, S[3:0]}; Cn is active-low carry-in
  localparam logic [OP_WIDTH-1:0] OP_ADD    = 6'b0_1_1001;
  localparam logic [OP_WIDTH-1:0] OP_SUB    = 6'b0_0_0110;
  localparam logic [OP_WIDTH-1:0] OP_AND    = 6'b1_1_1011;
  localparam logic [OP_WIDTH-1:0] OP_OR     = 6'b1_1_1110;
  localparam logic [OP_WIDTH-1:0] OP_XOR    = 6'b1_1_0110;
  localparam logic [OP_WIDTH-1:0] OP_PASS_A = 6'b1_1_1111;

endpackage

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - sequences one read/ALU/write-back register operation per command
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int OP_WIDTH    = regfile_seq_pkg::OP_WIDTH,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic                  cmd_we,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout,
  input  logic                  alu_aeqb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_cout,
  output logic                  rsp_aeqb,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0]  LAT_M1      = CNT_WIDTH'(ALU_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_REGS_C  = (ADDR_WIDTH + 1)'(NUM_REGS);

  seq_state_t              r_state;
  seq_state_t              w_next_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0]   r_rs1;
  logic [ADDR_WIDTH-1:0]   r_rs2;
  logic [ADDR_WIDTH-1:0]   r_rd;
  logic [OP_WIDTH-1:0]     r_op;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_cout;
  logic                    r_aeqb;
  logic                    w_rd_ok;

  assign w_rd_ok = ({1'b0, r_rd} < NUM_REGS_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_op     <= '0;
      r_we     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_aeqb   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_rs1 <= cmd_rs1;
            r_rs2 <= cmd_rs2;
            r_rd  <= cmd_rd;
            r_op  <= cmd_op;
            r_we  <= cmd_we;
          end
        end
        ST_READ: begin
          r_a   <= rf_read_data1;
          r_b   <= rf_read_data2;
          r_cnt <= LAT_M1;
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_result <= alu_result;
            r_cout   <= alu_cout;
            r_aeqb   <= alu_aeqb;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state    = r_state;
    cmd_ready       = 1'b0;
    busy            = 1'b1;
    rsp_valid       = 1'b0;
    rf_write_enable = 1'b0;
    rsp_err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = ~reset;
        busy      = 1'b0;
        if (cmd_valid) w_next_state = ST_READ;
      end
      ST_READ: w_next_state = ST_EXEC;
      ST_EXEC: if (r_cnt == '0) w_next_state = ST_WB;
      ST_WB: begin
        rsp_valid       = 1'b1;
        rf_write_enable = r_we & w_rd_ok;
        rsp_err         = r_we & ~w_rd_ok;
        w_next_state    = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Write address/data are always driven; only the strobe qualifies the write
  assign rf_read_addr1 = r_rs1;
  assign rf_read_addr2 = r_rs2;
  assign rf_write_addr = r_rd;
  assign rf_write_data = r_result;
  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_op        = r_op;
  assign rsp_result    = r_result;
  assign rsp_cout      = r_cout;
  assign rsp_aeqb      = r_aeqb;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer at ALU latencies 1 and 3
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        aeqb;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  function automatic logic [17:0] alu_f(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] f;
    logic        c;
    s = 17'd0; f = 16'd0; c = 1'b0;
    case (op)
      OP_ADD:    begin s = {1'b0, a} + {1'b0, b};         f = s[15:0]; c = s[16]; end
      OP_SUB:    begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; f = s[15:0]; c = s[16]; end
      OP_AND:    f = a & b;
      OP_OR:     f = a | b;
      OP_XOR:    f = a ^ b;
      OP_PASS_A: f = a;
      default:   f = 16'd0;
    endcase
    return {c, (a == b), f};
  endfunction

  // DUT 1: latency 1, six registers
  logic        reset1 = 1'b1;
  logic        d1_valid = 1'b0, d1_ready, d1_we = 1'b0;
  logic [2:0]  d1_rs1 = '0, d1_rs2 = '0, d1_rd = '0;
  logic [5:0]  d1_op = '0, d1_aop;
  logic [2:0]  d1_ra1, d1_ra2, d1_wa;
  logic [15:0] d1_rdat1, d1_rdat2, d1_wd, d1_a, d1_b, d1_res, d1_rres;
  logic        d1_wen, d1_cout, d1_aeqb, d1_rv, d1_rc, d1_rq, d1_err, d1_busy;
  logic [15:0] rf1 [8];
  logic        pl1_en = 1'b0;
  logic [2:0]  pl1_addr = '0;
  logic [15:0] pl1_data = '0;
  int          wcnt1 = 0;
  logic [2:0]  last_wa1 = '0;

  regfile_sequencer #(.DATA_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3), .OP_WIDTH(6), .ALU_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .cmd_valid(d1_valid), .cmd_ready(d1_ready),
    .cmd_rs1(d1_rs1), .cmd_rs2(d1_rs2), .cmd_rd(d1_rd), .cmd_op(d1_op), .cmd_we(d1_we),
    .rf_read_addr1(d1_ra1), .rf_read_addr2(d1_ra2), .rf_read_data1(d1_rdat1), .rf_read_data2(d1_rdat2),
    .rf_write_enable(d1_wen), .rf_write_addr(d1_wa), .rf_write_data(d1_wd),
    .alu_a(d1_a), .alu_b(d1_b), .alu_op(d1_aop), .alu_result(d1_res), .alu_cout(d1_cout), .alu_aeqb(d1_aeqb),
    .rsp_valid(d1_rv), .rsp_result(d1_rres), .rsp_cout(d1_rc), .rsp_aeqb(d1_rq), .rsp_err(d1_err), .busy(d1_busy)
  );

  assign d1_rdat1 = rf1[d1_ra1];
  assign d1_rdat2 = rf1[d1_ra2];
  assign {d1_cout, d1_aeqb, d1_res} = alu_f(d1_aop, d1_a, d1_b);

  always @(posedge clk) begin
    if (pl1_en) rf1[pl1_addr] <= pl1_data;
    else if (d1_wen) begin
      rf1[d1_wa] <= d1_wd;
      wcnt1      <= wcnt1 + 1;
      last_wa1   <= d1_wa;
    end
  end

  // DUT 3: latency 3, eight registers
  logic        reset3 = 1'b1;
  logic        d3_valid = 1'b0, d3_ready, d3_we = 1'b0;
  logic [2:0]  d3_rs1 = '0, d3_rs2 = '0, d3_rd = '0;
  logic [5:0]  d3_op = '0, d3_aop;
  logic [2:0]  d3_ra1, d3_ra2, d3_wa;
  logic [15:0] d3_rdat1, d3_rdat2, d3_wd, d3_a, d3_b, d3_res, d3_rres;
  logic        d3_wen, d3_cout, d3_aeqb, d3_rv, d3_rc, d3_rq, d3_err, d3_busy;
  logic [15:0] rf3 [8];
  logic        pl3_en = 1'b0;
  logic [2:0]  pl3_addr = '0;
  logic [15:0] pl3_data = '0;
  int          wcnt3 = 0;

  regfile_sequencer #(.DATA_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3), .OP_WIDTH(6), .ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3), .cmd_valid(d3_valid), .cmd_ready(d3_ready),
    .cmd_rs1(d3_rs1), .cmd_rs2(d3_rs2), .cmd_rd(d3_rd), .cmd_op(d3_op), .cmd_we(d3_we),
    .rf_read_addr1(d3_ra1), .rf_read_addr2(d3_ra2), .rf_read_data1(d3_rdat1), .rf_read_data2(d3_rdat2),
    .rf_write_enable(d3_wen), .rf_write_addr(d3_wa), .rf_write_data(d3_wd),
    .alu_a(d3_a), .alu_b(d3_b), .alu_op(d3_aop), .alu_result(d3_res), .alu_cout(d3_cout), .alu_aeqb(d3_aeqb),
    .rsp_valid(d3_rv), .rsp_result(d3_rres), .rsp_cout(d3_rc), .rsp_aeqb(d3_rq), .rsp_err(d3_err), .busy(d3_busy)
  );

  assign d3_rdat1 = rf3[d3_ra1];
  assign d3_rdat2 = rf3[d3_ra2];
  assign {d3_cout, d3_aeqb, d3_res} = alu_f(d3_aop, d3_a, d3_b);

  always @(posedge clk) begin
    if (pl3_en) rf3[pl3_addr] <= pl3_data;
    else if (d3_wen) begin
      rf3[d3_wa] <= d3_wd;
      wcnt3      <= wcnt3 + 1;
    end
  end

  task automatic preload1(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); pl1_en = 1'b1; pl1_addr = a; pl1_data = d;
    @(posedge clk); #1 pl1_en = 1'b0;
  endtask

  task automatic preload3(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); pl3_en = 1'b1; pl3_addr = a; pl3_data = d;
    @(posedge clk); #1 pl3_en = 1'b0;
  endtask

  // Returns after handshake edge k plus 1 time unit
  task automatic issue1(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic [5:0] op, input logic we);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d1_ready) break;
    end
    d1_rs1 = rs1; d1_rs2 = rs2; d1_rd = rd; d1_op = op; d1_we = we; d1_valid = 1'b1;
    @(posedge clk); #1 d1_valid = 1'b0;
  endtask

  task automatic issue3(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic [5:0] op, input logic we);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d3_ready) break;
    end
    d3_rs1 = rs1; d3_rs2 = rs2; d3_rd = rd; d3_op = op; d3_we = we; d3_valid = 1'b1;
    @(posedge clk); #1 d3_valid = 1'b0;
  endtask

  // Cycle offset after handshake at which rsp_valid is seen; 0 if never within budget
  task automatic wait_rsp1(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (d1_rv) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%b want=0", d1_ready); end
    checks++; if ({d1_busy, d1_rv, d1_wen, d1_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", {d1_busy, d1_rv, d1_wen, d1_err}); end
    checks++; if ({d1_a, d1_b, d1_wd, d1_rres} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", {d1_a, d1_b, d1_wd, d1_rres}); end
    checks++; if ({d1_ra1, d1_ra2, d1_wa, d1_aop} !== 15'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", {d1_ra1, d1_ra2, d1_wa, d1_aop}); end
    reset1 = 1'b0; reset3 = 1'b0;
    @(negedge clk);
    checks++; if ({d1_ready, d3_ready} !== 2'b11) begin errors++; $display("FAIL reset_release_ready got=%b want=11", {d1_ready, d3_ready}); end
  endtask

  task automatic test_simple_add;
    int n, w0;
    exp_t e;
    preload1(3'd1, 16'h1234);
    preload1(3'd2, 16'h0101);
    w0 = wcnt1;
    sb.push_back('{res: 16'h1335, cout: 1'b0, aeqb: 1'b0, err: 1'b0});
    issue1(3'd1, 3'd2, 3'd3, OP_ADD, 1'b1);
    wait_rsp1(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL add_latency got=%0d want=3", n); end
    checks++; if (d1_wen !== 1'b1) begin errors++; $display("FAIL add_strobe got=%b want=1", d1_wen); end
    e = sb.pop_front();
    checks++; if ({d1_rres, d1_rc, d1_rq, d1_err} !== e) begin errors++; $display("FAIL add_rsp got=%h want=%h", {d1_rres, d1_rc, d1_rq, d1_err}, e); end
    @(posedge clk); #1;
    checks++; if (wcnt1 !== w0 + 1) begin errors++; $display("FAIL add_write_count got=%0d want=%0d", wcnt1 - w0, 1); end
    checks++; if (last_wa1 !== 3'd3) begin errors++; $display("FAIL add_write_addr got=%0d want=3", last_wa1); end
    checks++; if (rf1[3] !== 16'h1335) begin errors++; $display("FAIL add_r3 got=%h want=1335", rf1[3]); end
  endtask

  task automatic test_back_to_back;
    int n;
    exp_t e;
    sb.push_back('{res: 16'h1335, cout: 1'b0, aeqb: 1'b0, err: 1'b0});
    sb.push_back('{res: 16'h266A, cout: 1'b0, aeqb: 1'b1, err: 1'b0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d1_ready) break;
    end
    d1_rs1 = 3'd1; d1_rs2 = 3'd2; d1_rd = 3'd3; d1_op = OP_ADD; d1_we = 1'b1; d1_valid = 1'b1;
    @(posedge clk); #1;
    d1_rs1 = 3'd3; d1_rs2 = 3'd3; d1_rd = 3'd4;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (d1_ready !== (c == 4)) begin errors++; $display("FAIL b2b_ready_c%0d got=%b want=%b", c, d1_ready, (c == 4)); end
      if (c == 3) begin
        checks++;
        if (!d1_rv || sb.size() == 0) begin errors++; $display("FAIL b2b_rsp1_valid got=%b want=1", d1_rv); end
        else begin
          e = sb.pop_front();
          if ({d1_rres, d1_rc, d1_rq, d1_err} !== e) begin errors++; $display("FAIL b2b_rsp1 got=%h want=%h", {d1_rres, d1_rc, d1_rq, d1_err}, e); end
        end
      end
    end
    @(posedge clk); #1 d1_valid = 1'b0;
    wait_rsp1(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_latency2 got=%0d want=3", n); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL b2b_rsp2 got=empty want=entry"); end
    else begin
      e = sb.pop_front();
      if ({d1_rres, d1_rc, d1_rq, d1_err} !== e) begin errors++; $display("FAIL b2b_rsp2 got=%h want=%h", {d1_rres, d1_rc, d1_rq, d1_err}, e); end
    end
    @(posedge clk); #1;
    checks++; if (rf1[4] !== 16'h266A) begin errors++; $display("FAIL b2b_r4 got=%h want=266a", rf1[4]); end
  endtask

  task automatic test_compare_only;
    int n, w0;
    exp_t e;
    preload1(3'd1, 16'h00FF);
    preload1(3'd2, 16'h00FF);
    w0 = wcnt1;
    sb.push_back('{res: 16'h0000, cout: 1'b1, aeqb: 1'b1, err: 1'b0});
    issue1(3'd1, 3'd2, 3'd3, OP_SUB, 1'b0);
    wait_rsp1(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL cmp_latency got=%0d want=3", n); end
    checks++; if (d1_wen !== 1'b0) begin errors++; $display("FAIL cmp_no_strobe got=%b want=0", d1_wen); end
    e = sb.pop_front();
    checks++; if ({d1_rres, d1_rc, d1_rq, d1_err} !== e) begin errors++; $display("FAIL cmp_rsp got=%h want=%h", {d1_rres, d1_rc, d1_rq, d1_err}, e); end
    @(posedge clk); #1;
    checks++; if (wcnt1 !== w0) begin errors++; $display("FAIL cmp_write_count got=%0d want=0", wcnt1 - w0); end
    checks++; if ({rf1[1], rf1[2], rf1[3]} !== {16'h00FF, 16'h00FF, 16'h1335}) begin errors++; $display("FAIL cmp_file got=%h want=00ff00ff1335", {rf1[1], rf1[2], rf1[3]}); end
  endtask

  task automatic test_out_of_range;
    int n, w0;
    exp_t e;
    w0 = wcnt1;
    sb.push_back('{res: 16'h01FE, cout: 1'b0, aeqb: 1'b1, err: 1'b1});
    issue1(3'd1, 3'd2, 3'd7, OP_ADD, 1'b1);
    wait_rsp1(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL oor_latency got=%0d want=3", n); end
    checks++; if (d1_wen !== 1'b0) begin errors++; $display("FAIL oor_no_strobe got=%b want=0", d1_wen); end
    e = sb.pop_front();
    checks++; if ({d1_rres, d1_rc, d1_rq, d1_err} !== e) begin errors++; $display("FAIL oor_rsp got=%h want=%h", {d1_rres, d1_rc, d1_rq, d1_err}, e); end
    @(posedge clk); #1;
    checks++; if (wcnt1 !== w0) begin errors++; $display("FAIL oor_write_count got=%0d want=0", wcnt1 - w0); end
  endtask

  task automatic test_latency_sweep;
    int n;
    exp_t e;
    preload3(3'd1, 16'h0003);
    preload3(3'd2, 16'h0005);
    sb.push_back('{res: 16'h0008, cout: 1'b0, aeqb: 1'b0, err: 1'b0});
    issue3(3'd1, 3'd2, 3'd7, OP_ADD, 1'b1);
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        checks++; if ({d3_a, d3_b, d3_aop} !== {16'h0003, 16'h0005, OP_ADD}) begin errors++; $display("FAIL sweep_stable_c%0d got=%h want=%h", c, {d3_a, d3_b, d3_aop}, {16'h0003, 16'h0005, OP_ADD}); end
      end
      if (d3_rv) begin n = c; break; end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL sweep_latency got=%0d want=5", n); end
    e = sb.pop_front();
    checks++; if ({d3_rres, d3_rc, d3_rq, d3_err} !== e) begin errors++; $display("FAIL sweep_rsp got=%h want=%h", {d3_rres, d3_rc, d3_rq, d3_err}, e); end
    @(posedge clk); #1;
    checks++; if (rf3[7] !== 16'h0008) begin errors++; $display("FAIL sweep_r7 got=%h want=0008", rf3[7]); end
  endtask

  task automatic test_reset_mid_op;
    int w0, seen;
    preload3(3'd1, 16'hAAAA);
    preload3(3'd2, 16'h1111);
    w0 = wcnt3;
    issue3(3'd1, 3'd2, 3'd5, OP_OR, 1'b1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset3 = 1'b1;
    #1;
    checks++; if ({d3_ready, d3_busy, d3_rv, d3_wen, d3_err} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags got=%b want=00000", {d3_ready, d3_busy, d3_rv, d3_wen, d3_err}); end
    checks++; if ({d3_a, d3_b, d3_wd, d3_rres, d3_ra1, d3_ra2, d3_wa, d3_aop} !== 79'd0) begin errors++; $display("FAIL rst_mid_data got=%h want=0", {d3_a, d3_b, d3_wd, d3_rres, d3_ra1, d3_ra2, d3_wa, d3_aop}); end
    @(negedge clk); reset3 = 1'b0;
    @(negedge clk);
    checks++; if (d3_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", d3_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d3_rv) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got=%0d want=0", seen); end
    checks++; if (wcnt3 !== w0 || rf3[5] !== 16'h0000) begin errors++; $display("FAIL rst_mid_no_write got=%0d/%h want=0/0000", wcnt3 - w0, rf3[5]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf1[i] = 16'h0000;
      rf3[i] = 16'h0000;
    end
    test_reset;
    test_simple_add;
    test_back_to_back;
    test_compare_only;
    test_out_of_range;
    test_latency_sweep;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
